// File: rtl/atax_stream_if.sv
// rtl/atax_stream_if.sv - x / A input streams and y output stream of atax_stream
interface atax_stream_if #(
  parameter int DW   = 16,
  parameter int ACCW = 40
);
  logic            x_valid;
  logic            x_ready;
  logic [DW-1:0]   x_data;
  logic            a_valid;
  logic            a_ready;
  logic [DW-1:0]   a_data;
  logic            y_valid;
  logic            y_ready;
  logic [ACCW-1:0] y_data;

  // Front-end / collector side: sources x and A, sinks y.
  modport master (
    output x_valid, x_data, a_valid, a_data, y_ready,
    input  x_ready, a_ready, y_valid, y_data
  );

  // Kernel side: sinks x and A, sources y.
  modport slave (
    input  x_valid, x_data, a_valid, a_data, y_ready,
    output x_ready, a_ready, y_valid, y_data
  );
endinterface

// File: rtl/atax_stream.sv
// rtl/atax_stream.sv - streaming y = A^T * (A * x) kernel with LANES-wide second pass
module atax_stream #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int ACCW  = 40,
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  atax_stream_if.slave s
);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int AW     = $clog2(N * N);
  localparam int GROUPS = N / LANES;

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_A, COMP_Y, OUT} state_t;

  state_t state_q, state_d;

  // i_q is the row index; j_q is the column in LOAD_X/LOAD_A/OUT and the
  // column group in COMP_Y.
  logic [IW-1:0] i_q, j_q;
  logic          done_q;

  logic [DW-1:0]          a_mem [N*N];
  logic [DW-1:0]          x_mem [N];
  logic signed [ACCW-1:0] tmp_q [N];
  logic signed [ACCW-1:0] y_q   [N];

  logic x_fire, a_fire, y_fire, start_ok;
  logic i_last, j_last, g_last;

  logic [AW-1:0] a_wr_addr;
  logic [IW-1:0] lane_col  [LANES];
  logic [AW-1:0] lane_addr [LANES];

  logic            x_ready_c, a_ready_c, y_valid_c;
  logic [ACCW-1:0] y_data_c;

  // Sign-extend an element to accumulator width; multiplying two ACCW-wide
  // operands into an ACCW result keeps exactly the low ACCW product bits.
  function automatic logic signed [ACCW-1:0] sext(input logic [DW-1:0] v);
    return ACCW'($signed(v));
  endfunction

  // A start coinciding with the done pulse is part of the finished job's
  // handoff and is ignored; the next cycle accepts it.
  assign start_ok = (state_q == IDLE) && start && !done_q;
  assign x_fire   = (state_q == LOAD_X) && s.x_valid;
  assign a_fire   = (state_q == LOAD_A) && s.a_valid;
  assign y_fire   = (state_q == OUT) && s.y_ready;
  assign i_last   = (i_q == IW'(N - 1));
  assign j_last   = (j_q == IW'(N - 1));
  assign g_last   = (j_q == IW'(GROUPS - 1));

  // Row-major write address for A and the per-lane read columns/addresses.
  always_comb begin
    a_wr_addr = AW'(int'(i_q) * N + int'(j_q));
    for (int k = 0; k < LANES; k++) begin
      lane_col[k]  = IW'(int'(j_q) * LANES + k);
      lane_addr[k] = AW'(int'(i_q) * N + int'(lane_col[k]));
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    x_ready_c = 1'b0;
    a_ready_c = 1'b0;
    y_valid_c = 1'b0;
    y_data_c  = '0;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD_X;
      LOAD_X: begin
        x_ready_c = 1'b1;
        if (x_fire && j_last) state_d = LOAD_A;
      end
      LOAD_A: begin
        a_ready_c = 1'b1;
        if (a_fire && i_last && j_last) state_d = COMP_Y;
      end
      COMP_Y:  if (i_last && g_last) state_d = OUT;
      OUT: begin
        y_valid_c = 1'b1;
        y_data_c  = y_q[j_q];
        if (y_fire && j_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s.x_ready = x_ready_c;
  assign s.a_ready = a_ready_c;
  assign s.y_valid = y_valid_c;
  assign s.y_data  = y_data_c;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // State register, index counters and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            i_q <= '0;
            j_q <= '0;
          end
        end
        LOAD_X: begin
          if (x_fire) j_q <= j_last ? '0 : j_q + 1'b1;
        end
        LOAD_A: begin
          if (a_fire) begin
            if (j_last) begin
              j_q <= '0;
              i_q <= i_last ? '0 : i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        COMP_Y: begin
          if (i_last) begin
            i_q <= '0;
            j_q <= g_last ? '0 : j_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        OUT: begin
          if (y_fire) begin
            j_q <= j_last ? '0 : j_q + 1'b1;
            if (j_last) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // tmp accumulates A*x while A streams in; y accumulates A^T*tmp per lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        tmp_q[k] <= '0;
        y_q[k]   <= '0;
      end
    end else if (start_ok) begin
      for (int k = 0; k < N; k++) begin
        tmp_q[k] <= '0;
        y_q[k]   <= '0;
      end
    end else if (a_fire) begin
      tmp_q[i_q] <= tmp_q[i_q] + sext(s.a_data) * sext(x_mem[j_q]);
    end else if (state_q == COMP_Y) begin
      for (int k = 0; k < LANES; k++) begin
        y_q[lane_col[k]] <= y_q[lane_col[k]] + sext(a_mem[lane_addr[k]]) * tmp_q[i_q];
      end
    end
  end

  // x and A storage; every job overwrites them completely, so no reset.
  always_ff @(posedge clk) begin
    if (x_fire) x_mem[j_q] <= s.x_data;
    if (a_fire) a_mem[a_wr_addr] <= s.a_data;
  end
endmodule
